// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit
//   Decoupled RV32I instruction fetch stage. It issues word-aligned fetch
//   requests on a valid/ready channel, takes in-order responses into a small
//   prefetch FIFO tagged with their PCs, and presents the FIFO head to ID.
//   A redirect from EX flushes the FIFO and marks every in-flight response
//   (including one accepted in the redirect cycle) for discard.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   redirect_valid/pc   EX control-flow redirect (pc[1:0] ignored)
//   imem_req_*          fetch request channel (valid/ready, word address)
//   imem_rsp_*          in-order response channel (no backpressure)
//   if_*                instruction presented to ID (valid, pc, pc+4, instr)
//   id_ready            ID consumes the presented instruction this cycle
module rv32_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  cnt_t          r_fifo_cnt;
  cnt_t          r_outstanding;
  cnt_t          r_discard;

  logic [31:0] w_target;
  logic [CW:0] w_credit_used;
  logic        w_req_hs;
  logic        w_pop;
  logic        w_push;
  logic        w_rsp_drop;
  logic [31:0] w_fetch_pc_next;
  logic [31:0] w_rsp_pc_next;
  cnt_t        w_fifo_cnt_next;
  cnt_t        w_out_next;
  cnt_t        w_discard_next;

  assign w_target = {redirect_pc[31:2], 2'b00};

  // Credit covers both buffered and in-flight words (stale ones included),
  // so a response always finds a free FIFO slot.
  assign w_credit_used  = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
  assign imem_req_valid = (w_credit_used < L_DEPTH);
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_hs   = imem_req_valid & imem_req_ready;
  assign w_rsp_drop = imem_rsp_valid & (r_discard != '0);
  // A redirect empties the FIFO, so a same-cycle push or pop must not land.
  assign w_push     = imem_rsp_valid & (r_discard == '0) & ~redirect_valid;
  assign w_pop      = if_valid & id_ready & ~redirect_valid;

  assign if_valid    = (r_fifo_cnt != '0);
  assign if_pc       = r_fifo_pc[r_rd_ptr];
  assign if_instr    = r_fifo_instr[r_rd_ptr];
  assign if_pc_plus4 = if_pc + 32'd4;

  always_comb begin
    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_fetch_pc_next = r_fetch_pc;
    w_rsp_pc_next   = r_rsp_pc;
    w_fifo_cnt_next = r_fifo_cnt;
    w_discard_next  = r_discard;
    w_out_next      = r_outstanding + cnt_t'(w_req_hs) - cnt_t'(imem_rsp_valid);

    if (redirect_valid) begin
      w_fetch_pc_next = w_target;
      w_rsp_pc_next   = w_target;
      w_fifo_cnt_next = '0;
      // Everything still in flight after this edge belongs to the old path,
      // including a request accepted this cycle with the old fetch_pc.
      w_discard_next  = w_out_next;
    end else begin
      if (w_req_hs)   w_fetch_pc_next = r_fetch_pc + 32'd4;
      if (w_push)     w_rsp_pc_next   = r_rsp_pc + 32'd4;
      if (w_rsp_drop) w_discard_next  = r_discard - cnt_t'(1);
      w_fifo_cnt_next = r_fifo_cnt + cnt_t'(w_push) - cnt_t'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_fifo_cnt    <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      r_fetch_pc    <= w_fetch_pc_next;
      r_rsp_pc      <= w_rsp_pc_next;
      r_fifo_cnt    <= w_fifo_cnt_next;
      r_outstanding <= w_out_next;
      r_discard     <= w_discard_next;
      if (redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // NOTE: the storage array is reset on purpose: ID must see if_pc = 0 and
  // if_instr = 0 out of reset, and the head is read straight from storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit
//   Drives rv32_fetch_unit with an in-order instruction memory of variable
//   latency and compares every cycle against a transaction-level model:
//   requests carry an epoch tag, a redirect starts a new epoch, and only
//   responses from the current epoch may ever reach ID.
module tb_rv32_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        id_ready = 1'b0;

  rv32_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mreq_t       mq[$];     // accepted, not yet answered (memory + outstanding)
  ent_t        q[$];      // what ID must see, in order
  int          epoch    = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  logic [31:0] exp_req_addr = RESET_PC;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input logic rdv, input logic [31:0] rdpc,
                      input logic idr, input logic rrdy);
    logic hs, pop, rsp;
    int   lat, due;
    mreq_t e;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    id_ready       = idr;
    imem_req_ready = rrdy;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    check("if_valid", 32'(if_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("if_pc", if_pc, q[0].pc);
      check("if_instr", if_instr, q[0].instr);
      check("if_pc_plus4", if_pc_plus4, q[0].pc + 32'd4);
    end
    check("req_valid", 32'(imem_req_valid), 32'((q.size() + mq.size()) < DEPTH));
    check("req_addr", imem_req_addr, exp_req_addr);
    hs  = imem_req_valid & rrdy;
    pop = if_valid & idr;
    rsp = imem_rsp_valid;
    @(posedge clk);
    if (rsp) begin
      e = mq.pop_front();
      if (e.epoch == epoch && !rdv) q.push_back('{pc: e.addr, instr: mem_word(e.addr)});
    end
    if (pop && !rdv && q.size() != 0) void'(q.pop_front());
    if (hs) begin
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: exp_req_addr, epoch: epoch, due: due});
      exp_req_addr += 32'd4;
    end
    if (rdv) begin
      epoch++;
      q.delete();
      exp_req_addr = {rdpc[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  // Hold reset, check reset values, release on a falling edge.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    q.delete();
    epoch++;
    last_due     = 0;
    exp_req_addr = RESET_PC;
    #1;
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h4);
    check("rst_if_instr", if_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h1);
    check("rst_req_addr", imem_req_addr, RESET_PC);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid && n < 30) begin
      idle_step();
      n++;
    end
    check(name, 32'(if_valid), 32'h1);
  endtask

  initial begin
    // Reset and streaming: 1-cycle memory, everything ready.
    lat_min = 1; lat_max = 1;
    do_reset();
    idle_step();
    check("stream_valid_1cyc", 32'(if_valid), 32'h0);
    idle_step();
    check("stream_valid_2cyc", 32'(if_valid), 32'h1);
    check("stream_pc0", if_pc, 32'h0);
    check("stream_instr0", if_instr, 32'h13);
    idle_step();
    check("stream_pc1", if_pc, 32'h4);
    idle_step();
    check("stream_pc2", if_pc, 32'h8);
    repeat (12) idle_step();

    // Backpressure: ID stalls, FIFO fills, requests stop.
    do_reset();
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_full_valid", 32'(if_valid), 32'h1);
    check("stall_req_off", 32'(imem_req_valid), 32'h0);
    check("stall_pc_held", if_pc, 32'h0);
    check("stall_instr_held", if_instr, 32'h13);
    for (int k = 0; k < 5; k++) begin
      check("release_pc_seq", if_pc, 32'(4 * k));
      idle_step();
    end

    // Redirect with traffic in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (8) idle_step();
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    wait_valid("redir_wait");
    check("redir_pc", if_pc, 32'h100);
    check("redir_instr", if_instr, mem_word(32'h100));
    repeat (10) idle_step();

    // Redirect coinciding with a request handshake, a response and a pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    begin
      int n = 0;
      while (imem_req_addr != 32'h40 && n < 50) begin
        idle_step();
        n++;
      end
    end
    #1;
    check("coinc_addr", imem_req_addr, 32'h40);
    check("coinc_req_valid", 32'(imem_req_valid), 32'h1);
    check("coinc_pop_avail", 32'(if_valid), 32'h1);
    step(1'b1, 32'h0000_0203, 1'b1, 1'b1);
    check("coinc_next_addr", imem_req_addr, 32'h200);
    wait_valid("coinc_wait");
    check("coinc_pc", if_pc, 32'h200);
    repeat (6) idle_step();

    // Back-to-back redirects: the later one wins.
    repeat (4) idle_step();
    step(1'b1, 32'h0000_0080, 1'b1, 1'b1);
    step(1'b1, 32'h0000_00C0, 1'b1, 1'b1);
    wait_valid("b2b_wait");
    check("b2b_pc", if_pc, 32'hC0);
    repeat (10) idle_step();

    // Address wrap, then asynchronous reset between clock edges.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    wait_valid("wrap_wait");
    check("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", if_pc_plus4, 32'h0);
    idle_step();
    check("wrap_pc_zero", if_pc, 32'h0);
    repeat (3) idle_step();
    #2 rst_n = 1'b0;
    #1;
    check("async_if_valid", 32'(if_valid), 32'h0);
    check("async_req_addr", imem_req_addr, RESET_PC);
    do_reset();
    repeat (5) idle_step();

    // Randomized traffic: variable latency, backpressure, random redirects.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rdv;
      logic [31:0] rpc;
      rdv = ($urandom_range(99, 0) < 4);
      rpc = $urandom;
      if ($urandom_range(9, 0) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      step(rdv, rpc, ($urandom_range(99, 0) < 70), ($urandom_range(99, 0) < 75));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
